flex_pts_framer: RTL and testbench
==================================

// Module: flex_pts_framer
// PURPOSE
//   Parametrised parallel-to-serial framer: next generation of the flex shift register.
//   - Adds a valid/ready load handshake and a one-word pending buffer for gapless back-to-back frames.
//   - Frame length and bit order are selected per word at run time.
//   - Shifts one bit per shift_enable tick from an external bit-rate strobe; sits between the
//     word source and the serial line driver.
// PARAMETERS
//   NUM_BITS   16                      max frame data width (>=2)
//   CNT_W      $clog2(NUM_BITS+1)      width of frame_len and internal bit counter
//   IDLE_VAL   1'b1                    serial_out level when idle; fill value shifted in
//   PARITY_ODD 1'b0                    parity sense, used only with PTS_PARITY_EN (0=even, 1=odd)
// PORTS
//   clk          in   1         clock, all state updates on rising edge
//   rst          in   1         reset; one clock; reset is synchronous and active-high
//   shift_enable in   1         bit-rate tick; advances one bit when high in SHIFT/PARITY state
//   load_valid   in   1         parallel_in/frame_len/msb_first valid
//   load_ready   out  1         pending buffer empty; word accepted when load_valid & load_ready
//   parallel_in  in   NUM_BITS  frame data; bits [frame_len-1:0] transmitted
//   frame_len    in   CNT_W     data bits per frame, 1..NUM_BITS; 0 or >NUM_BITS means NUM_BITS
//   msb_first    in   1         1: send bit frame_len-1 first; 0: send bit 0 first
//   serial_out   out  1         registered serial line
//   busy         out  1         high in SHIFT or PARITY state
//   frame_done   out  1         one-cycle pulse, cycle after final bit period ends
// BEHAVIOUR
//   - Reset (sampled high at an edge): state=IDLE, pending discarded, shifter filled with IDLE_VAL.
//     Outputs: serial_out=IDLE_VAL, busy=0, frame_done=0, load_ready=1.
//     Reset mid-frame aborts the frame with no frame_done pulse.
//   - Accept: on an edge with load_valid&load_ready, data, effective frame_len and msb_first are
//     captured into pending together. load_ready=!pend_full is registered, not combinational.
//     The load_ready fall and rise rules are part of the Transfer rule below.
//   - States: IDLE, SHIFT, PARITY (PARITY exists only with PTS_PARITY_EN).
//   - IDLE: if pend_full, transfer pending into shifter at next edge -> SHIFT.
//     Transfer latency: 1 cycle after accept; first bit on serial_out the cycle after transfer.
//     shift_enable is ignored in IDLE.
//   - Transfer: load bit counter=len.
//     MSB-first: left-align so data[len-1] sits at the output tap.
//     LSB-first: data[0] at the output tap.
//     Unused positions are filled with IDLE_VAL.
//     Same edge: pend_full clears and load_ready rises next cycle.
//     An accept on the transfer edge is not possible (load_ready was 0).
//   - SHIFT: each edge with shift_enable=1 advances one bit (fill IDLE_VAL) and decrements the counter.
//     Each bit is held until the next tick.
//     On the tick ending the last bit:
//     - With PTS_PARITY_EN -> PARITY.
//     - Else frame_done=1 next cycle, and the state goes either:
//       - to SHIFT with an immediate transfer if pend_full (no idle gap), or
//       - to IDLE with serial_out=IDLE_VAL.
//   - Counter never wraps: len=NUM_BITS needs CNT_W bits; frame_len clamps as above.
// CONFIGURATION
//   PTS_PARITY_EN defined:
//   - A running XOR of the transmitted data bits is kept.
//   - After the last data tick, PARITY state drives XOR^PARITY_ODD for one tick period.
//   - The tick ending it behaves as the last data tick (frame_done, transfer/IDLE). busy stays high.
//   PTS_PARITY_EN undefined: no PARITY state or XOR logic; PARITY_ODD unused; frames are data only.
// TESTING
//   1 mid-frame rst=1 for 2 cycles -> serial_out=1, busy=0, load_ready=1, no frame_done pulse
//   2 NUM_BITS=16, 0xA5C3, len=0, msb_first=1, tick every cycle -> 1010010111000011, one frame_done, then 1
//   3 0x0013, len=5, msb_first=0, tick every cycle -> 1,1,0,0,1 then IDLE_VAL; busy high exactly 5 bit periods
//   4 accept 0x00FF then 0xFF00 while busy -> load_ready low until second transfer; 32 contiguous bits, 2 frame_done
//   5 tick every 4th cycle, load_valid held while load_ready=0 -> each bit 4 cycles wide; held word sent intact
//   6 PTS_PARITY_EN, PARITY_ODD=0, 0x0007, len=3, LSB-first -> 1,1,1,parity 1, then frame_done

Source files
------------

// File: rtl/flex_pts_framer.sv
// Parallel-to-serial framer with a valid/ready load handshake, a one-word pending buffer and per-word length/bit order.
// Optional parity bit after the data bits when PTS_PARITY_EN is defined.
module flex_pts_framer #(
    parameter int   NUM_BITS   = 16,
    parameter int   CNT_W      = $clog2(NUM_BITS + 1),
    parameter logic IDLE_VAL   = 1'b1,
    parameter logic PARITY_ODD = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_enable,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [NUM_BITS-1:0] parallel_in,
    input  logic [CNT_W-1:0]    frame_len,
    input  logic                msb_first,
    output logic                serial_out,
    output logic                busy,
    output logic                frame_done
);

    localparam logic [CNT_W-1:0]    FULL_LEN = CNT_W'(NUM_BITS);
    localparam logic [CNT_W-1:0]    ONE      = CNT_W'(1);
    localparam logic [NUM_BITS-1:0] FILL     = {NUM_BITS{IDLE_VAL}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT
`ifdef PTS_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t                state_reg, state_next;
    logic [NUM_BITS-1:0]   shift_reg, shift_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  msb_reg, msb_next;
    logic                  pend_full_reg, pend_full_next;
    logic [NUM_BITS-1:0]   pend_data_reg, pend_data_next;
    logic [CNT_W-1:0]      pend_len_reg, pend_len_next;
    logic                  pend_msb_reg, pend_msb_next;
    logic                  ready_reg, ready_next;
    logic                  done_reg, done_next;
    logic                  serial_reg, serial_next;
`ifdef PTS_PARITY_EN
    logic                  par_reg, par_next;
`else
    logic                  unused_cfg;
    assign unused_cfg = PARITY_ODD;
`endif

    logic [CNT_W-1:0]      eff_len;
    logic [CNT_W-1:0]      align_sh;
    logic [NUM_BITS-1:0]   shifted_data;
    logic [NUM_BITS-1:0]   msb_aligned;
    logic [NUM_BITS-1:0]   lsb_aligned;
    logic [NUM_BITS-1:0]   load_word;
    logic [NUM_BITS-1:0]   advanced;
    logic                  tap;
    logic                  end_frame;
    logic                  transfer;

    // Out-of-range lengths (0 or above NUM_BITS) mean a full-width frame.
    assign eff_len = ((frame_len == '0) || (frame_len > FULL_LEN)) ? FULL_LEN : frame_len;

    assign align_sh     = FULL_LEN - pend_len_reg;
    assign shifted_data = pend_data_reg << align_sh;

    generate
        for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_align
            localparam logic [CNT_W-1:0] POS = CNT_W'(gi);
            assign msb_aligned[gi] = (POS >= align_sh)     ? shifted_data[gi]  : IDLE_VAL;
            assign lsb_aligned[gi] = (POS <  pend_len_reg) ? pend_data_reg[gi] : IDLE_VAL;
        end
    endgenerate

    assign load_word = pend_msb_reg ? msb_aligned : lsb_aligned;
    assign tap       = msb_reg ? shift_reg[NUM_BITS-1] : shift_reg[0];
    assign advanced  = msb_reg ? {shift_reg[NUM_BITS-2:0], IDLE_VAL}
                               : {IDLE_VAL, shift_reg[NUM_BITS-1:1]};

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        cnt_next       = cnt_reg;
        msb_next       = msb_reg;
        pend_full_next = pend_full_reg;
        pend_data_next = pend_data_reg;
        pend_len_next  = pend_len_reg;
        pend_msb_next  = pend_msb_reg;
        done_next      = 1'b0;
        end_frame      = 1'b0;
        transfer       = 1'b0;
`ifdef PTS_PARITY_EN
        par_next       = par_reg;
`endif

        case (state_reg)
            S_IDLE: transfer = pend_full_reg;
            S_SHIFT: begin
                if (shift_enable) begin
                    shift_next = advanced;
                    cnt_next   = cnt_reg - ONE;
`ifdef PTS_PARITY_EN
                    par_next = par_reg ^ tap;
                    if (cnt_reg == ONE) begin
                        state_next = S_PARITY;
                    end
`else
                    end_frame = (cnt_reg == ONE);
`endif
                end
            end
`ifdef PTS_PARITY_EN
            S_PARITY: end_frame = shift_enable;
`endif
            default: state_next = S_IDLE;
        endcase

        // A waiting word follows the finished frame on the same edge, so there is no idle gap.
        if (end_frame) begin
            done_next  = 1'b1;
            state_next = S_IDLE;
            shift_next = FILL;
            transfer   = pend_full_reg;
        end

        if (transfer) begin
            state_next     = S_SHIFT;
            shift_next     = load_word;
            cnt_next       = pend_len_reg;
            msb_next       = pend_msb_reg;
            pend_full_next = 1'b0;
`ifdef PTS_PARITY_EN
            par_next       = 1'b0;
`endif
        end

        // load_ready is low whenever a transfer can happen, so accept and transfer never coincide.
        if (load_valid && ready_reg) begin
            pend_full_next = 1'b1;
            pend_data_next = parallel_in;
            pend_len_next  = eff_len;
            pend_msb_next  = msb_first;
        end

        ready_next  = !pend_full_next;
        serial_next = msb_next ? shift_next[NUM_BITS-1] : shift_next[0];
`ifdef PTS_PARITY_EN
        if (state_next == S_PARITY) begin
            serial_next = par_next ^ PARITY_ODD;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            shift_reg     <= FILL;
            cnt_reg       <= '0;
            msb_reg       <= 1'b0;
            pend_full_reg <= 1'b0;
            pend_data_reg <= '0;
            pend_len_reg  <= '0;
            pend_msb_reg  <= 1'b0;
            ready_reg     <= 1'b1;
            done_reg      <= 1'b0;
            serial_reg    <= IDLE_VAL;
`ifdef PTS_PARITY_EN
            par_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            cnt_reg       <= cnt_next;
            msb_reg       <= msb_next;
            pend_full_reg <= pend_full_next;
            pend_data_reg <= pend_data_next;
            pend_len_reg  <= pend_len_next;
            pend_msb_reg  <= pend_msb_next;
            ready_reg     <= ready_next;
            done_reg      <= done_next;
            serial_reg    <= serial_next;
`ifdef PTS_PARITY_EN
            par_reg       <= par_next;
`endif
        end
    end

    assign load_ready = ready_reg;
    assign serial_out = serial_reg;
    assign frame_done = done_reg;
    assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_flex_pts_framer.sv
// Directed testbench for flex_pts_framer: reset abort, frame orders/lengths, back-to-back frames, slow ticks, parity.
module tb_flex_pts_framer;

    localparam int NUM_BITS = 16;
    localparam int CNT_W    = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                shift_enable = 1'b0;
    logic                load_valid = 1'b0;
    logic                msb_first = 1'b0;
    logic [NUM_BITS-1:0] parallel_in = '0;
    logic [CNT_W-1:0]    frame_len = '0;
    logic                load_ready;
    logic                serial_out;
    logic                busy;
    logic                frame_done;

    int vectors     = 0;
    int miscompares = 0;
    int tick_period = 1;

    logic [63:0] cap_bits;
    logic        cap_lr [64];
    int          cap_done;
    int          cap_busy;
    int          cap_lr_low;
    int          cap_done_idx;

    always #5 clk = ~clk;

    flex_pts_framer #(
        .NUM_BITS  (NUM_BITS),
        .CNT_W     (CNT_W),
        .IDLE_VAL  (1'b1),
        .PARITY_ODD(1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .shift_enable(shift_enable),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .parallel_in (parallel_in),
        .frame_len   (frame_len),
        .msb_first   (msb_first),
        .serial_out  (serial_out),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs n edges, dropping load_valid once the held word is taken, and records outputs after each edge.
    task automatic run_cycles(input int n);
        logic lr_before;
        cap_bits     = '0;
        cap_done     = 0;
        cap_busy     = 0;
        cap_lr_low   = 0;
        cap_done_idx = -1;
        for (int i = 0; i < n; i++) begin
            shift_enable = ((i % tick_period) == 0);
            lr_before    = load_ready;
            step();
            if (load_valid && lr_before) load_valid = 1'b0;
            cap_bits  = {cap_bits[62:0], serial_out};
            cap_lr[i] = load_ready;
            if (!load_ready) cap_lr_low++;
            if (busy) cap_busy++;
            if (frame_done) begin
                cap_done++;
                cap_done_idx = i;
            end
        end
    endtask

    task automatic start_word(input logic [15:0] data, input logic [4:0] len, input logic msb);
        for (int k = 0; k < 50 && load_ready !== 1'b1; k++) step();
        vectors++;
        if (load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL start_ready: load_ready=%b required 1 within 50 cycles", load_ready);
        end
        parallel_in = data;
        frame_len   = len;
        msb_first   = msb;
        load_valid  = 1'b1;
        step();
        load_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++;
        if ({serial_out, busy, load_ready, frame_done} !== 4'b1010) begin
            miscompares++;
            $display("FAIL reset_state: {ser,busy,rdy,done}=%b required 1010",
                     {serial_out, busy, load_ready, frame_done});
        end
        rst = 1'b0;
        tick_period = 1;
        start_word(16'h0000, 5'd0, 1'b1);
        parallel_in = 16'h1234;
        load_valid  = 1'b1;
        run_cycles(5);
        vectors++;
        if (busy !== 1'b1 || serial_out !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe: busy=%b ser=%b required 1 0", busy, serial_out);
        end
        rst = 1'b1;
        step();
        vectors++;
        if ({serial_out, busy, load_ready, frame_done} !== 4'b1010) begin
            miscompares++;
            $display("FAIL reset_abort: {ser,busy,rdy,done}=%b required 1010",
                     {serial_out, busy, load_ready, frame_done});
        end
        step();
        rst = 1'b0;
        run_cycles(20);
        vectors++;
        if (cap_done !== 0 || cap_busy !== 0) begin
            miscompares++;
            $display("FAIL reset_no_done: done=%0d busy=%0d required 0 0", cap_done, cap_busy);
        end
        vectors++;
        if (cap_bits[19:0] !== 20'hFFFFF) begin
            miscompares++;
            $display("FAIL reset_idle_line: bits=%h required fffff", cap_bits[19:0]);
        end
        $display("test_reset: mid-frame reset applied");
    endtask

    task automatic test_msb_full();
        tick_period = 1;
        start_word(16'hA5C3, 5'd0, 1'b1);
        vectors++;
        if (load_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL accept_ready_low: load_ready=%b required 0", load_ready);
        end
        run_cycles(17);
        vectors++;
        if (cap_bits[16:0] !== 17'h14B87) begin
            miscompares++;
            $display("FAIL msb_full_bits: bits=%h required 14b87", cap_bits[16:0]);
        end
        vectors++;
        if (cap_done !== 1 || cap_done_idx !== 16 || cap_busy !== 16) begin
            miscompares++;
            $display("FAIL msb_full_ctl: done=%0d at %0d busy=%0d required 1 at 16 busy 16",
                     cap_done, cap_done_idx, cap_busy);
        end
        vectors++;
        if (cap_lr[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL transfer_ready_rise: load_ready=%b required 1", cap_lr[0]);
        end
        $display("test_msb_full: 0xA5C3 len=0 msb-first");
    endtask

    task automatic test_lsb_short();
        tick_period = 1;
        start_word(16'h0013, 5'd5, 1'b0);
        run_cycles(6);
        vectors++;
        if (cap_bits[5:0] !== 6'b110011) begin
            miscompares++;
            $display("FAIL lsb_short_bits: bits=%b required 110011", cap_bits[5:0]);
        end
        vectors++;
        if (cap_busy !== 5 || cap_done !== 1 || cap_done_idx !== 5) begin
            miscompares++;
            $display("FAIL lsb_short_ctl: busy=%0d done=%0d at %0d required 5 1 at 5",
                     cap_busy, cap_done, cap_done_idx);
        end
        $display("test_lsb_short: 0x0013 len=5 lsb-first");
    endtask

    task automatic test_len_bounds();
        tick_period = 1;
        start_word(16'h8001, 5'd20, 1'b1);
        run_cycles(17);
        vectors++;
        if (cap_bits[16:0] !== 17'h10003 || cap_busy !== 16) begin
            miscompares++;
            $display("FAIL len_clamp: bits=%h busy=%0d required 10003 16", cap_bits[16:0], cap_busy);
        end
        start_word(16'h0002, 5'd1, 1'b1);
        run_cycles(2);
        vectors++;
        if (cap_bits[1:0] !== 2'b01 || cap_busy !== 1 || cap_done !== 1) begin
            miscompares++;
            $display("FAIL len_one: bits=%b busy=%0d done=%0d required 01 1 1",
                     cap_bits[1:0], cap_busy, cap_done);
        end
        $display("test_len_bounds: len=20 clamp and len=1");
    endtask

    task automatic test_back_to_back();
        tick_period = 1;
        start_word(16'h00FF, 5'd0, 1'b1);
        parallel_in = 16'hFF00;
        frame_len   = 5'd0;
        msb_first   = 1'b1;
        load_valid  = 1'b1;
        run_cycles(34);
        vectors++;
        if (cap_bits[33:0] !== {16'h00FF, 16'hFF00, 2'b11}) begin
            miscompares++;
            $display("FAIL b2b_bits: bits=%h required %h", cap_bits[33:0], {16'h00FF, 16'hFF00, 2'b11});
        end
        vectors++;
        if (cap_done !== 2 || cap_busy !== 32) begin
            miscompares++;
            $display("FAIL b2b_ctl: done=%0d busy=%0d required 2 32", cap_done, cap_busy);
        end
        vectors++;
        if (cap_lr_low !== 15 || cap_lr[15] !== 1'b0 || cap_lr[16] !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready: low=%0d r15=%b r16=%b required 15 0 1",
                     cap_lr_low, cap_lr[15], cap_lr[16]);
        end
        $display("test_back_to_back: 0x00FF then 0xFF00");
    endtask

    task automatic test_slow_tick();
        tick_period = 4;
        start_word(16'hFFF5, 5'd4, 1'b0);
        parallel_in = 16'h123C;
        frame_len   = 5'd4;
        msb_first   = 1'b1;
        load_valid  = 1'b1;
        run_cycles(36);
        vectors++;
        if (cap_bits[35:0] !== 36'hF0F0FF00F) begin
            miscompares++;
            $display("FAIL slow_bits: bits=%h required f0f0ff00f", cap_bits[35:0]);
        end
        vectors++;
        if (cap_done !== 2 || cap_busy !== 32 || load_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL slow_ctl: done=%0d busy=%0d lv=%b required 2 32 0",
                     cap_done, cap_busy, load_valid);
        end
        tick_period = 1;
        $display("test_slow_tick: tick every 4th cycle with held word");
    endtask

`ifdef PTS_PARITY_EN
    task automatic test_parity();
        tick_period = 1;
        start_word(16'h0007, 5'd3, 1'b0);
        run_cycles(6);
        vectors++;
        if (cap_bits[5:0] !== 6'b111111 || cap_busy !== 4 || cap_done_idx !== 4) begin
            miscompares++;
            $display("FAIL parity_7: bits=%b busy=%0d done_at=%0d required 111111 4 4",
                     cap_bits[5:0], cap_busy, cap_done_idx);
        end
        start_word(16'h0005, 5'd3, 1'b0);
        run_cycles(6);
        vectors++;
        if (cap_bits[5:0] !== 6'b101011 || cap_busy !== 4 || cap_done !== 1) begin
            miscompares++;
            $display("FAIL parity_5: bits=%b busy=%0d done=%0d required 101011 4 1",
                     cap_bits[5:0], cap_busy, cap_done);
        end
        $display("test_parity: even parity frames");
    endtask
`endif

    initial begin
        test_reset();
`ifdef PTS_PARITY_EN
        test_parity();
`else
        test_msb_full();
        test_lsb_short();
        test_len_bounds();
        test_back_to_back();
        test_slow_tick();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
